// File: rtl/nest_counter_pkg.sv
// -----------------------------------------------------------------------------
// nest_counter_pkg
// Shared definitions for the nested loop counter.
//   MAX_DIM          : largest supported number of nested dimensions
//   state_e          : run-control states (IDLE, RUN)
//   ST_IDLE / ST_RUN : the same encodings as plain logic constants, which the
//                      FSM register and the debug port use directly
// -----------------------------------------------------------------------------
package nest_counter_pkg;

  localparam int MAX_DIM = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_RUN  = 1'(RUN);

endpackage

// File: rtl/nest_counter_dim.sv
// -----------------------------------------------------------------------------
// nest_counter_dim
// One dimension of the nested loop counter: a CW-bit index that steps from 0
// to bound-1 and then wraps back to 0.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   inc       : advance this dimension by one this cycle
//   clr       : synchronous clear to 0 (wins over inc)
//   bound     : trip count of this dimension (only meaningful when nonzero)
//   cnt       : current index
//   at_last   : cnt == bound-1
//   wrap      : inc & at_last, the carry into the next outer dimension
// -----------------------------------------------------------------------------
module nest_counter_dim #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  input  logic [CW-1:0] bound,
  output logic [CW-1:0] cnt,
  output logic          at_last,
  output logic          wrap
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] bound_m1;

  // bound is never 0 while inc can be asserted, so bound-1 never underflows
  // in a way that matters; a bound of 1 keeps at_last high at index 0.
  assign bound_m1 = bound - CW'(1);
  assign at_last  = (cnt_q == bound_m1);
  assign wrap     = inc & at_last;
  assign cnt      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = at_last ? '0 : (cnt_q + CW'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nest_counter.sv
// -----------------------------------------------------------------------------
// nest_counter
// Multi-dimensional loop counter producing nested loop indices, dimension 0
// innermost. A run is started from IDLE with start, which latches the
// per-dimension bounds; each ena while busy advances one iteration; the cycle
// after the final iteration done pulses and the counter is back in IDLE.
//
// Handshake: start is accepted only in IDLE (ignored in RUN); ena is accepted
// only in RUN (ignored in IDLE, including the start cycle); clear is accepted
// in any state and overrides both. done is a single-cycle pulse that may
// coincide with a new start, which is then accepted normally.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin a run, latching bound (IDLE only)
//   bound      : trip counts, dim d at [d*CW +: CW]; any zero gives an empty run
//   ena        : advance one iteration (RUN only)
//   clear      : synchronous abort to IDLE, no done pulse
//   cnt        : current indices, dim d at [d*CW +: CW]
//   last       : per-dimension "at final index", gated by busy
//   busy       : high while in RUN
//   done       : one-cycle pulse after a run completes
//   dbg_state  : current FSM state (ST_IDLE / ST_RUN)
//
// DIM must lie in 1..MAX_DIM.
// -----------------------------------------------------------------------------
module nest_counter
  import nest_counter_pkg::*;
#(
  parameter int CW  = 16,
  parameter int DIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM*CW-1:0] bound,
  input  logic              ena,
  input  logic              clear,
  output logic [DIM*CW-1:0] cnt,
  output logic [DIM-1:0]    last,
  output logic              busy,
  output logic              done,
  output logic [0:0]        dbg_state
);

  logic [0:0]        state_q;
  logic [0:0]        state_d;
  logic              busy_q;
  logic              busy_d;
  logic              done_q;
  logic              done_d;
  logic [DIM*CW-1:0] bound_q;
  logic [DIM*CW-1:0] bound_d;

  logic [DIM-1:0]    at_last;
  logic              any_zero;
  logic              all_last;
  logic              step;
  logic              final_step;

  // ---------------------------------------------------------------------------
  // Iteration control
  // ---------------------------------------------------------------------------
  // One iteration is consumed on every ena while running, unless clear aborts.
  assign step     = (state_q == ST_RUN) & ena & ~clear;
  assign all_last = &at_last;

  // Empty-run detect on the incoming bounds.
  always_comb begin
    any_zero = 1'b0;
    for (int d = 0; d < DIM; d++) begin
      if (bound[d*CW +: CW] == '0) begin
        any_zero = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Dimension chain: each dimension is advanced by the carry of the one inside
  // it, so the whole tuple updates in the same cycle. Per-iteration scalars
  // keep the carry chain free of vector-level combinational loops.
  // ---------------------------------------------------------------------------
  for (genvar d = 0; d < DIM; d++) begin : g_dim
    logic          inc_l;
    logic          wrap_l;
    logic          at_last_l;
    logic [CW-1:0] cnt_l;

    if (d == 0) begin : g_first
      assign inc_l = step;
    end else begin : g_rest
      assign inc_l = g_dim[d-1].wrap_l;
    end

    nest_counter_dim #(
      .CW (CW)
    ) u_dim (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc_l),
      .clr     (clear),
      .bound   (bound_q[d*CW +: CW]),
      .cnt     (cnt_l),
      .at_last (at_last_l),
      .wrap    (wrap_l)
    );

    assign at_last[d]       = at_last_l;
    assign cnt[d*CW +: CW]  = cnt_l;
  end

  // The carry out of the outermost dimension already implies every at_last
  // bit; the explicit AND states the full-tuple condition directly.
  assign final_step = g_dim[DIM-1].wrap_l & all_last;

  // ---------------------------------------------------------------------------
  // Run-control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    bound_d = bound_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            bound_d = bound;
            if (any_zero) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // The counters wrap to 0 on their own at the final step.
          if (final_step) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bound_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bound_q <= bound_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign last      = busy_q ? at_last : '0;
  assign dbg_state = state_q;

endmodule
